// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register and writeback mux of the 5-stage
//               RV32I core. It registers MEM-stage results and selects the
//               writeback value (ALU result, load data or PC+4). Load data
//               arrives combinationally from the synchronous data memory in
//               the WB cycle. A hold buffer keeps that data valid across WB
//               stalls. The block also drives the register-file write port,
//               the WB forwarding source, a retire pulse and the instret
//               counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk          clock
//   i_reset        asynchronous active-low reset
//   i_stall        hold the WB register contents
//   i_flush        load a bubble into WB (ignored while i_stall=1)
//   i_mem_valid    MEM-stage instruction valid
//   i_mem_pc       MEM-stage PC
//   i_mem_alu      ALU result / effective address
//   i_mem_rd       destination register
//   i_mem_rd_wren  instruction writes rd
//   i_mem_wb_sel   00 ALU, 01 load, 10 PC+4, 11 treated as ALU
//   i_ld_data      LSU load data, valid in the cycle the load occupies WB
//   o_wb_valid     WB holds a valid instruction
//   o_wb_rd        register-file write address
//   o_wb_rd_wren   register-file write enable (never asserted for x0)
//   o_wb_data      writeback / forwarding data
//   o_wb_is_load   WB instruction is a load (for the hazard unit)
//   o_retire       one-cycle pulse when the WB instruction leaves
//   o_instret      retired-instruction count, wraps modulo 2^INSTRET_W
// ============================================================================
module mem_wb_stage #(
  parameter int INSTRET_W = 64
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic                 i_mem_valid,
  input  logic [31:0]          i_mem_pc,
  input  logic [31:0]          i_mem_alu,
  input  logic [4:0]           i_mem_rd,
  input  logic                 i_mem_rd_wren,
  input  logic [1:0]           i_mem_wb_sel,
  input  logic [31:0]          i_ld_data,
  output logic                 o_wb_valid,
  output logic [4:0]           o_wb_rd,
  output logic                 o_wb_rd_wren,
  output logic [31:0]          o_wb_data,
  output logic                 o_wb_is_load,
  output logic                 o_retire,
  output logic [INSTRET_W-1:0] o_instret
);

  localparam logic [1:0]           c_SEL_LOAD = 2'b01;
  localparam logic [1:0]           c_SEL_PC4  = 2'b10;
  localparam logic [INSTRET_W-1:0] c_INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  // WB pipeline register
  logic                 r_wb_valid;
  logic [31:0]          r_wb_pc;
  logic [31:0]          r_wb_alu;
  logic [4:0]           r_wb_rd;
  logic                 r_wb_rd_wren;
  logic [1:0]           r_wb_sel;

  // Load hold buffer
  logic [31:0]          r_ld_hold;
  logic                 r_hold_vld;

  logic [INSTRET_W-1:0] r_instret;

  logic                 w_is_load;
  logic                 w_retire;
  logic [31:0]          w_ld_value;
  logic [31:0]          w_wb_data;

  assign w_is_load = r_wb_valid & (r_wb_sel == c_SEL_LOAD);
  assign w_retire  = r_wb_valid & ~i_stall;

  // Once the load data has been captured, the LSU output is no longer
  // trusted: its delayed controls and the memory output may move during
  // the stall.
  assign w_ld_value = r_hold_vld ? r_ld_hold : i_ld_data;

  always_comb begin
    w_wb_data = r_wb_alu;
    case (r_wb_sel)
      c_SEL_LOAD: w_wb_data = w_ld_value;
      c_SEL_PC4:  w_wb_data = r_wb_pc + 32'd4;
      default:    w_wb_data = r_wb_alu;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wb_valid   <= 1'b0;
      r_wb_pc      <= 32'd0;
      r_wb_alu     <= 32'd0;
      r_wb_rd      <= 5'd0;
      r_wb_rd_wren <= 1'b0;
      r_wb_sel     <= 2'b00;
      r_ld_hold    <= 32'd0;
      r_hold_vld   <= 1'b0;
    end else if (i_stall) begin
      // Stall beats flush. Capture the load value only in the first
      // stalled cycle, while i_ld_data is still the genuine response.
      if (w_is_load && !r_hold_vld) begin
        r_ld_hold  <= i_ld_data;
        r_hold_vld <= 1'b1;
      end
    end else if (i_flush) begin
      // Only the valid bit matters for a bubble; other fields may keep
      // stale values.
      r_wb_valid <= 1'b0;
      r_hold_vld <= 1'b0;
    end else begin
      r_wb_valid   <= i_mem_valid;
      r_wb_pc      <= i_mem_pc;
      r_wb_alu     <= i_mem_alu;
      r_wb_rd      <= i_mem_rd;
      r_wb_rd_wren <= i_mem_rd_wren;
      r_wb_sel     <= i_mem_wb_sel;
      r_hold_vld   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_instret <= {INSTRET_W{1'b0}};
    end else if (w_retire) begin
      r_instret <= r_instret + c_INSTRET_ONE;
    end
  end

  assign o_wb_valid   = r_wb_valid;
  assign o_wb_rd      = r_wb_rd;
  // Write enable stays high through a stall; rewriting the same value is
  // harmless. x0 is never written.
  assign o_wb_rd_wren = r_wb_valid & r_wb_rd_wren & (r_wb_rd != 5'd0);
  assign o_wb_data    = w_wb_data;
  assign o_wb_is_load = w_is_load;
  assign o_retire     = w_retire;
  assign o_instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage. Directed MEM-stage
//               vectors push hand-computed expected writeback results into
//               a queue. A monitor pops and compares an entry each time the
//               DUT retires an instruction. Directed checks cover reset,
//               stall, flush and the other cycles in which nothing retires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  localparam int INSTRET_W = 4;

  logic                 clk;
  logic                 i_reset;
  logic                 i_stall;
  logic                 i_flush;
  logic                 i_mem_valid;
  logic [31:0]          i_mem_pc;
  logic [31:0]          i_mem_alu;
  logic [4:0]           i_mem_rd;
  logic                 i_mem_rd_wren;
  logic [1:0]           i_mem_wb_sel;
  logic [31:0]          i_ld_data;
  logic                 o_wb_valid;
  logic [4:0]           o_wb_rd;
  logic                 o_wb_rd_wren;
  logic [31:0]          o_wb_data;
  logic                 o_wb_is_load;
  logic                 o_retire;
  logic [INSTRET_W-1:0] o_instret;

  mem_wb_stage #(.INSTRET_W(INSTRET_W)) u_dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .i_mem_valid   (i_mem_valid),
    .i_mem_pc      (i_mem_pc),
    .i_mem_alu     (i_mem_alu),
    .i_mem_rd      (i_mem_rd),
    .i_mem_rd_wren (i_mem_rd_wren),
    .i_mem_wb_sel  (i_mem_wb_sel),
    .i_ld_data     (i_ld_data),
    .o_wb_valid    (o_wb_valid),
    .o_wb_rd       (o_wb_rd),
    .o_wb_rd_wren  (o_wb_rd_wren),
    .o_wb_data     (o_wb_data),
    .o_wb_is_load  (o_wb_is_load),
    .o_retire      (o_retire),
    .o_instret     (o_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]          data;
    logic [4:0]           rd;
    logic                 wren;
    logic                 is_load;
    logic [INSTRET_W-1:0] instret;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cnt    = 0;   // retirements issued since the last reset

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next active edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mem(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                           input logic [4:0] rd, input logic wren, input logic [1:0] sel);
    i_mem_valid   = v;
    i_mem_pc      = pc;
    i_mem_alu     = alu;
    i_mem_rd      = rd;
    i_mem_rd_wren = wren;
    i_mem_wb_sel  = sel;
  endtask

  task automatic bubble();
    drive_mem(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
  endtask

  // Queue the expected result of an instruction that will retire.
  task automatic expect_retire(input logic [31:0] data, input logic [4:0] rd,
                               input logic wren, input logic is_load);
    exp_t e;
    e.data    = data;
    e.rd      = rd;
    e.wren    = wren;
    e.is_load = is_load;
    e.instret = INSTRET_W'(cnt);
    q.push_back(e);
    cnt++;
  endtask

  // Monitor: every retirement must match the oldest queued expectation.
  always @(negedge clk) begin
    if (i_reset && o_retire) begin
      if (q.size() == 0) begin
        chk("unexpected_retire", 64'(o_wb_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ret_data",    64'(o_wb_data),    64'(e.data));
        chk("ret_rd",      64'(o_wb_rd),      64'(e.rd));
        chk("ret_wren",    64'(o_wb_rd_wren), 64'(e.wren));
        chk("ret_is_load", 64'(o_wb_is_load), 64'(e.is_load));
        chk("ret_instret", 64'(o_instret),    64'(e.instret));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"},   64'(o_wb_valid),   64'd0);
    chk({tag, "_rd"},      64'(o_wb_rd),      64'd0);
    chk({tag, "_wren"},    64'(o_wb_rd_wren), 64'd0);
    chk({tag, "_data"},    64'(o_wb_data),    64'd0);
    chk({tag, "_is_load"}, 64'(o_wb_is_load), 64'd0);
    chk({tag, "_retire"},  64'(o_retire),     64'd0);
    chk({tag, "_instret"}, 64'(o_instret),    64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset   = 1'b0;
    i_stall   = 1'b0;
    i_flush   = 1'b0;
    i_ld_data = 32'hCAFE_F00D;
    bubble();
    #1;
    check_all_zero("reset");
    step();
    step();
    i_reset = 1'b1;

    // ALU op
    drive_mem(1'b1, 32'h100, 32'h0000_1234, 5'd5, 1'b1, 2'b00);
    expect_retire(32'h0000_1234, 5'd5, 1'b1, 1'b0);
    step();

    // Load without stall: data taken straight from i_ld_data
    drive_mem(1'b1, 32'h104, 32'h0000_2000, 5'd7, 1'b1, 2'b01);
    expect_retire(32'hDEAD_BEEF, 5'd7, 1'b1, 1'b1);
    step();
    chk("instret_after_alu", 64'(o_instret), 64'd1);
    i_ld_data = 32'hDEAD_BEEF;

    // Load followed by a 2-cycle stall; LSU data disappears after cycle 1
    drive_mem(1'b1, 32'h108, 32'h0000_2004, 5'd8, 1'b1, 2'b01);
    expect_retire(32'hDEAD_BEEF, 5'd8, 1'b1, 1'b1);
    step();
    bubble();
    i_ld_data = 32'hDEAD_BEEF;
    i_stall   = 1'b1;
    @(negedge clk);
    chk("stall1_data",   64'(o_wb_data),    64'hDEAD_BEEF);
    chk("stall1_retire", 64'(o_retire),     64'd0);
    step();
    i_ld_data = 32'h0000_0000;
    @(negedge clk);
    chk("stall2_data",   64'(o_wb_data),    64'hDEAD_BEEF);
    chk("stall2_retire", 64'(o_retire),     64'd0);
    chk("stall2_wren",   64'(o_wb_rd_wren), 64'd1);
    chk("stall2_instret", 64'(o_instret),   64'd2);
    step();
    i_stall = 1'b0;          // third WB cycle: retires through the monitor
    step();
    chk("instret_after_stall_load", 64'(o_instret), 64'd3);
    i_ld_data = 32'hCAFE_F00D;

    // JAL at the top of the address space: PC+4 wraps to 0
    drive_mem(1'b1, 32'hFFFF_FFFC, 32'h0000_5555, 5'd1, 1'b1, 2'b10);
    expect_retire(32'h0000_0000, 5'd1, 1'b1, 1'b0);
    step();
    // ALU op targeting x0: retires but never writes
    drive_mem(1'b1, 32'h0000_0000, 32'h0000_0077, 5'd0, 1'b1, 2'b00);
    expect_retire(32'h0000_0077, 5'd0, 1'b0, 1'b0);
    step();
    // sel=11 behaves like ALU
    drive_mem(1'b1, 32'h0000_0004, 32'h0000_ABCD, 5'd3, 1'b1, 2'b11);
    expect_retire(32'h0000_ABCD, 5'd3, 1'b1, 1'b0);
    step();

    // Flush a valid MEM instruction
    drive_mem(1'b1, 32'h0000_0008, 32'h0000_0099, 5'd9, 1'b1, 2'b00);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    bubble();
    @(negedge clk);
    chk("flush_valid",  64'(o_wb_valid), 64'd0);
    chk("flush_retire", 64'(o_retire),   64'd0);
    chk("flush_instret_a", 64'(o_instret), 64'd6);
    step();
    chk("flush_instret_b", 64'(o_instret), 64'd6);

    // Stall and flush together while WB holds a valid instruction
    drive_mem(1'b1, 32'h0000_0010, 32'h0000_4242, 5'd10, 1'b1, 2'b00);
    expect_retire(32'h0000_4242, 5'd10, 1'b1, 1'b0);
    step();
    drive_mem(1'b1, 32'h0000_0020, 32'h0000_0BAD, 5'd11, 1'b1, 2'b00);
    i_stall = 1'b1;
    i_flush = 1'b1;
    @(negedge clk);
    chk("stflush_valid",  64'(o_wb_valid), 64'd1);
    chk("stflush_retire", 64'(o_retire),   64'd0);
    step();
    i_stall = 1'b0;
    i_flush = 1'b0;
    bubble();
    @(negedge clk);
    chk("stflush_held_rd", 64'(o_wb_rd), 64'd10);
    step();

    // Counter wrap: push the 4-bit instret through 15 -> 0
    for (int k = 0; k < 10; k++) begin
      drive_mem(1'b1, 32'h0000_1000 + 32'(4 * k), 32'h0000_0300 + 32'(k),
                5'(k + 12), 1'b1, 2'b00);
      expect_retire(32'h0000_0300 + 32'(k), 5'(k + 12), 1'b1, 1'b0);
      step();
    end
    bubble();
    step();
    chk("instret_wrapped", 64'(o_instret), 64'd1);

    // Reset in the middle of a stalled load
    drive_mem(1'b1, 32'h0000_0500, 32'h0000_0600, 5'd12, 1'b1, 2'b01);
    step();
    bubble();
    i_ld_data = 32'h1234_5678;
    i_stall   = 1'b1;
    #1;
    i_reset = 1'b0;
    #1;
    check_all_zero("midreset");
    step();
    i_reset = 1'b1;
    i_stall = 1'b0;
    cnt     = 0;
    step();
    step();
    @(negedge clk);
    chk("postreset_valid",   64'(o_wb_valid), 64'd0);
    chk("postreset_instret", 64'(o_instret),  64'd0);

    // Counting restarts from zero after reset
    step();
    drive_mem(1'b1, 32'h0000_0600, 32'h0000_0042, 5'd4, 1'b1, 2'b00);
    expect_retire(32'h0000_0042, 5'd4, 1'b1, 1'b0);
    step();
    bubble();
    step();
    step();
    chk("final_instret", 64'(o_instret), 64'd1);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
